pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register for the RISC-V core, the successor to the fixed MEM/WB latch. It carries a control bundle and a data bundle between two pipeline stages using a valid/ready handshake. A two-entry skid buffer sustains one transfer per cycle without any combinational path from `out_ready` to `in_ready`. Synchronous flush inserts bubbles, and control bits are forced to their safe value whenever no valid instruction is presented.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_slot.sv | 22 ++
 rtl/pipe_stage_skid.sv | 129 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for pipeline stage registers between core stages.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam int CTRL_REG_WRITE    = 0;
    localparam int CTRL_MEM_TO_REG   = 1;
    localparam int PIPE_MEMWB_CTRL_W = 2;
    localparam int PIPE_MEMWB_DATA_W = 69;

endpackage

// File: rtl/pipe_slot.sv
// One {ctrl, data} holding register with load enable.
// Latency: 1 cycle from load to q.
// Backpressure: none; the owner decides when to load.
module pipe_slot #(
    parameter int W = 71
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a two-entry skid buffer (main + skid slot).
// Latency: 1 cycle; full throughput with out_ready held high.
// Backpressure: in_ready is registered, low only while both slots are held.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = PIPE_MEMWB_DATA_W,
    parameter int                CTRL_W      = PIPE_MEMWB_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int SLOT_W = CTRL_W + DATA_W;

    stage_state_t      state_q;
    stage_state_t      state_d;
    logic              in_ready_q;
    logic              acc;
    logic              fire;
    logic              load_main;
    logic              load_skid;
    logic [SLOT_W-1:0] main_d;
    logic [SLOT_W-1:0] main_q;
    logic [SLOT_W-1:0] skid_q;

    assign acc  = in_valid & in_ready_q;
    assign fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Flush only clears valid state; slot contents are left untouched.
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        main_d    = {in_ctrl, in_data};
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        load_main = 1'b1;
                        state_d   = BUSY;
                    end
                end
                BUSY: begin
                    if (acc && fire) begin
                        load_main = 1'b1;
                    end else if (acc) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (fire) begin
                        state_d   = EMPTY;
                    end
                end
                FULL: begin
                    main_d = skid_q;
                    if (fire) begin
                        load_main = 1'b1;
                        state_d   = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        occupancy = 2'd0;
        case (state_q)
            BUSY: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            FULL: begin
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
    end

    // A bubble must never leak stale control bits such as reg_write.
    assign out_ctrl = out_valid ? main_q[SLOT_W-1:DATA_W] : CTRL_BUBBLE;
    assign out_data = main_q[DATA_W-1:0];
    assign in_ready = in_ready_q;

    pipe_slot #(.W(SLOT_W)) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_main),
        .d       (main_d),
        .q       (main_q)
    );

    pipe_slot #(.W(SLOT_W)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_skid),
        .d       ({in_ctrl, in_data}),
        .q       (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, flush, async reset.
module tb_pipe_stage_skid;

    localparam int DATA_W = 69;
    localparam int CTRL_W = 2;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int passed;
    int total;

    pipe_stage_skid #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (2'b00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'b11;
        in_data   = 69'h1F;
        out_ready = 1'b0;

        // Reset held with live input
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_ctrl",  out_ctrl,  2'b00);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_out_data",  out_data,  69'h0);
        reset_n = 1'b1;

        // Streaming 1..4, one per cycle
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 69'(i);
            in_ctrl  = (i == 4) ? 2'b01 : 2'b10;
            step();
            check("stream_valid", out_valid, 1'b1);
            check("stream_data",  out_data,  69'(i));
            check("stream_occ",   occupancy, 2'd1);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid",  out_valid, 1'b0);
        check("drain_occ",    occupancy, 2'd0);
        check("bubble_ctrl",  out_ctrl,  2'b00);
        check("drain_ready",  in_ready,  1'b1);

        // Backpressure: A then B with out_ready dropped
        in_valid  = 1'b1;
        in_data   = 69'hA;
        in_ctrl   = 2'b11;
        out_ready = 1'b1;
        step();
        check("bp_a_data",  out_data,  69'hA);
        check("bp_a_occ",   occupancy, 2'd1);
        in_data   = 69'hB;
        in_ctrl   = 2'b10;
        out_ready = 1'b0;
        step();
        check("bp_full_occ",   occupancy, 2'd2);
        check("bp_full_ready", in_ready,  1'b0);
        check("bp_hold_a",     out_data,  69'hA);
        check("bp_hold_ctrl",  out_ctrl,  2'b11);
        in_data = 69'hC;
        step();
        check("bp_stall_occ",  occupancy, 2'd2);
        check("bp_stall_a",    out_data,  69'hA);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_b_data",  out_data,  69'hB);
        check("bp_b_ctrl",  out_ctrl,  2'b10);
        check("bp_b_occ",   occupancy, 2'd1);
        check("bp_b_ready", in_ready,  1'b1);
        step();
        check("bp_empty_valid", out_valid, 1'b0);
        check("bp_empty_occ",   occupancy, 2'd0);

        // Flush while FULL with a simultaneous input C
        in_valid  = 1'b1;
        in_data   = 69'h1A;
        in_ctrl   = 2'b01;
        out_ready = 1'b0;
        step();
        in_data = 69'h1B;
        step();
        check("fl_pre_occ", occupancy, 2'd2);
        flush     = 1'b1;
        in_data   = 69'h1C;
        in_ctrl   = 2'b11;
        out_ready = 1'b1;
        step();
        check("fl_valid", out_valid, 1'b0);
        check("fl_ctrl",  out_ctrl,  2'b00);
        check("fl_occ",   occupancy, 2'd0);
        check("fl_ready", in_ready,  1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check("fl_no_c_valid", out_valid, 1'b0);
        check("fl_no_c_occ",   occupancy, 2'd0);

        // Asynchronous reset while FULL
        in_valid  = 1'b1;
        in_data   = 69'h2D;
        in_ctrl   = 2'b11;
        out_ready = 1'b0;
        step();
        in_data = 69'h2E;
        step();
        check("ar_pre_occ", occupancy, 2'd2);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("ar_valid", out_valid, 1'b0);
        check("ar_ctrl",  out_ctrl,  2'b00);
        check("ar_data",  out_data,  69'h0);
        check("ar_ready", in_ready,  1'b1);
        check("ar_occ",   occupancy, 2'd0);
        #1;
        reset_n   = 1'b1;
        in_valid  = 1'b1;
        in_data   = 69'h3F;
        in_ctrl   = 2'b10;
        out_ready = 1'b1;
        step();
        check("ar_first_valid", out_valid, 1'b1);
        check("ar_first_data",  out_data,  69'h3F);
        check("ar_first_occ",   occupancy, 2'd1);
        in_valid = 1'b0;
        step();
        check("ar_end_valid", out_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
